// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic 2-entry skid-buffer stage register carrying
// ctrl/data/insn bundles across one pipeline boundary with valid/ready.
//
// Ports:
//   clk, reset_n (async, active-low), flush (sync, empties the stage)
//   in_valid/in_ready/in_ctrl/in_data/in_insn    : upstream beat
//   out_valid/out_ready/out_ctrl/out_data/out_insn : downstream beat
//   stall_cnt, bubble_cnt : perf counters, present only when the
//                           PIPE_STAGE_PERF_EN macro is defined
// Bubbles (out_valid=0) show zero ctrl/data and NOP_INSN.

`ifndef OPCODE_NOP
`define OPCODE_NOP 4'hF
`endif

module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 64,
  parameter int INSN_W = 16,
  parameter logic [INSN_W-1:0] NOP_INSN = {`OPCODE_NOP, 12'b0}
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [INSN_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [INSN_W-1:0] out_insn
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [INSN_W-1:0] main_insn, skid_insn;

  logic in_ready_q;
  logic main_v;
  logic push, pop;

  assign in_ready = in_ready_q;
  assign main_v   = (state != EMPTY);
  assign push     = in_valid & in_ready_q & ~flush;
  assign pop      = main_v & out_ready;

  // in_ready is a flop, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
      main_data  <= '0;
      main_insn  <= NOP_INSN;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      skid_insn  <= NOP_INSN;
    end else if (flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            main_insn <= in_insn;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            main_insn <= in_insn;
          end else if (push) begin
            state      <= FULL;
            in_ready_q <= 1'b0;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            skid_insn  <= in_insn;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            main_insn  <= skid_insn;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = main_v ? main_data : '0;
  assign out_insn  = main_v ? main_insn : NOP_INSN;

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; flush does not touch them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (!main_v && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register that replaces the fixed per-stage latch modules between IF/ID/EX/MEM/WB. It carries a control bundle, a data bundle and the instruction word through a 2-entry skid buffer with a valid/ready handshake, so a downstream stall does not combinationally propagate upstream. Flush and empty cycles present a bubble: zeroed control and a NOP instruction word. One instance sits on each stage boundary of the pipelined CPU.

## Interface
- CTRL_W, 16: width of control bundle (RegWrite, MemtoReg, d_readM, …)
- DATA_W, 64: width of data bundle (pc, operands, immediates, addresses)
- INSN_W, 16: instruction word width (`WORD_SIZE)
- NOP_INSN, {`OPCODE_NOP, 12'b0}: instruction word driven on bubbles
- CNT_W, 16: perf counter width (used only with PIPE_STAGE_PERF_EN)

- clk  input  1  clock, all state updates on posedge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; empties the stage at next posedge
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept; registered, depends on state only
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- in_insn  input  INSN_W  upstream instruction
- out_valid  output  1  downstream beat present
- out_ready  input  1  downstream accepts (~stall)
- out_ctrl  output  CTRL_W  control, 0 when !out_valid
- out_data  output  DATA_W  data, 0 when !out_valid
- out_insn  output  INSN_W  instruction, NOP_INSN when !out_valid
- stall_cnt  output  CNT_W  (PIPE_STAGE_PERF_EN only) stalled cycles
- bubble_cnt  output  CNT_W  (PIPE_STAGE_PERF_EN only) empty cycles

## Operation
- Storage: main entry (drives outputs) and skid entry; each has a valid bit.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
- EMPTY: push -> ONE, main <= input.
- ONE: push&pop -> ONE, main <= input; push&!pop -> FULL, skid <= input; pop&!push -> EMPTY.
- FULL: in_ready=0; pop -> ONE, main <= skid; else hold.
- in_ready = (state != FULL), registered; no combinational path out_ready -> in_ready.
- flush: next state EMPTY regardless of push/pop; the beat offered in the flush cycle is dropped; a pop in the flush cycle is still a valid transfer.
- Bubble: when out_valid=0, out_ctrl=0, out_data=0, out_insn=NOP_INSN (bubble values come from the output mux, not stale storage).
- Entries hold unchanged while stalled; no data change without push/pop.

## Timing
- Reset (async, reset_n=0): state EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_data=0, out_insn=NOP_INSN, counters 0. Reset mid-transfer discards both entries.
- Latency: push at edge N -> out_valid=1 with that beat after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready falls the cycle after the edge that enters FULL; it rises the cycle after the first pop from FULL.
- Ordering: strict FIFO; the skid beat is always older than any later push.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cnt +1 each cycle with out_valid&!out_ready; bubble_cnt +1 each cycle with !out_valid; both saturate at all-ones, cleared only by reset_n, unaffected by flush.
- Not defined: stall_cnt/bubble_cnt ports and logic absent.

## Test plan
- Reset: hold reset_n=0 with in_valid=1 -> out_valid=0, out_insn=NOP_INSN, in_ready=1; release, push insn 16'h1234 -> appears next cycle.
- Streaming: out_ready=1, push 0x0001..0x0008 back-to-back -> outputs the same sequence one cycle later, no gaps, in_ready stays 1.
- Stall/skid: push A, B with out_ready=0 -> FULL, in_ready=0, out holds A; raise out_ready -> A then B emitted, in_ready back to 1 after first pop.
- Flush: FULL with A, B; assert flush with in_valid=1 (C) -> next cycle EMPTY, out_insn=NOP_INSN, out_ctrl=0, C never emitted.
- Simultaneous push/pop in ONE: main A, push B with out_ready=1 -> A accepted, next cycle out=B, state ONE.
- Perf (PIPE_STAGE_PERF_EN, CNT_W=4): 20 stalled cycles -> stall_cnt=15 (saturated); 3 empty cycles -> bubble_cnt=3.
